// File: rtl/sgemm_addr_pkg.sv
// Shared types and default widths for the SGEMM address sequencer.
package sgemm_addr_pkg;

  localparam int IDX_WIDTH_DEF   = 63;
  localparam int BYTES_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF   = 16;
  localparam int MUL_LAT_DEF     = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

  typedef enum logic {ROW_MAJOR, COL_MAJOR} walk_order_t;

endpackage

// File: rtl/sgemm_addr_vld_pipe.sv
// Valid-bit shadow of the external multiplier pipeline. Shifts only when the
// multiplier is clock-enabled so each bit stays aligned with its product.
module sgemm_addr_vld_pipe
  import sgemm_addr_pkg::*;
#(
  parameter int DEPTH = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic any_valid
);

  logic [DEPTH-1:0] sr;

  // Shift register advancing in lock-step with the multiplier stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout      = sr[DEPTH-1];
  assign any_valid = |sr;

endmodule

// File: rtl/sgemm_addr_seq.sv
// SGEMM tile address sequencer: walks a rows_n x cols_n tile, feeds element
// indices to an external MUL_LAT-deep multiplier and streams base + product.
// Optional feature macro: SGEMM_ADDR_SEQ_TRANSPOSE_EN adds the transpose input
// (column-major walk); without it the walk is row-major only.
module sgemm_addr_seq
  import sgemm_addr_pkg::*;
#(
  parameter int IDX_WIDTH   = IDX_WIDTH_DEF,
  parameter int BYTES_WIDTH = BYTES_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int MUL_LAT     = MUL_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   rows_n,
  input  logic [CNT_WIDTH-1:0]   cols_n,
  input  logic [IDX_WIDTH-1:0]   ld,
  input  logic [IDX_WIDTH-1:0]   idx0,
  input  logic [BYTES_WIDTH-1:0] elem_bytes,
  input  logic [IDX_WIDTH-1:0]   base_addr,
`ifdef SGEMM_ADDR_SEQ_TRANSPOSE_EN
  input  logic                   transpose,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   mul_ce,
  output logic [IDX_WIDTH-1:0]   mul_din0,
  output logic [BYTES_WIDTH-1:0] mul_din1,
  input  logic [IDX_WIDTH-1:0]   mul_dout,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic [IDX_WIDTH-1:0]   addr_data
);

  localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

  seq_state_t             state;
  walk_order_t            start_order;
  logic                   transpose_in;
  logic                   adv;
  logic                   issue_vld;
  logic                   pipe_out;
  logic                   any_valid;
  logic [CNT_WIDTH-1:0]   in_cnt, out_cnt, in_last, out_last;
  logic [IDX_WIDTH-1:0]   cur_idx, line_idx, in_step, out_step, base_q;

`ifdef SGEMM_ADDR_SEQ_TRANSPOSE_EN
  assign transpose_in = transpose;
`else
  assign transpose_in = 1'b0;
`endif

  assign start_order = transpose_in ? COL_MAJOR : ROW_MAJOR;

  // The whole pipe moves only when the output register can take a new value.
  assign adv    = !addr_valid || addr_ready;
  assign mul_ce = reset || adv;

  // Sequencer FSM and tile walk. The walk is generic: an inner counter stepping
  // cur_idx by in_step and an outer counter stepping the line start by out_step;
  // the walk order only decides which dimension is inner and what the steps are.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_vld <= 1'b0;
      mul_din0  <= '0;
      mul_din1  <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      in_last   <= '0;
      out_last  <= '0;
      cur_idx   <= '0;
      line_idx  <= '0;
      in_step   <= '0;
      out_step  <= '0;
      base_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            cur_idx  <= idx0;
            line_idx <= idx0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            base_q   <= base_addr;
            mul_din1 <= elem_bytes;
            if (start_order == COL_MAJOR) begin
              in_last  <= rows_n - 1'b1;
              out_last <= cols_n - 1'b1;
              in_step  <= ld;
              out_step <= IDX_ONE;
            end else begin
              in_last  <= cols_n - 1'b1;
              out_last <= rows_n - 1'b1;
              in_step  <= IDX_ONE;
              out_step <= ld;
            end
            state <= (rows_n == '0 || cols_n == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (adv) begin
            issue_vld <= 1'b1;
            mul_din0  <= cur_idx;
            if (in_cnt == in_last) begin
              in_cnt   <= '0;
              out_cnt  <= out_cnt + 1'b1;
              line_idx <= line_idx + out_step;
              cur_idx  <= line_idx + out_step;
              if (out_cnt == out_last) state <= DRAIN;
            end else begin
              in_cnt  <= in_cnt + 1'b1;
              cur_idx <= cur_idx + in_step;
            end
          end
        end
        DRAIN: begin
          if (adv) issue_vld <= 1'b0;
          // Leave as the last address is being accepted so done follows it directly.
          if (!issue_vld && !any_valid && adv) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // Drain exit already raised done; the empty-tile path raises it here.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= ~done;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sgemm_addr_vld_pipe #(.DEPTH(MUL_LAT)) u_vld_pipe (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .din       (issue_vld),
    .dout      (pipe_out),
    .any_valid (any_valid)
  );

  // Output register: re-joins the product with its valid bit and adds the base.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_valid <= 1'b0;
      addr_data  <= '0;
    end else if (adv) begin
      addr_valid <= pipe_out;
      if (pipe_out) addr_data <= base_q + mul_dout;
    end
  end

endmodule
